// File: rtl/instruction_loader_pkg.sv
// Shared loader/bank types: instruction bank geometry, header magic and loader state codes.
// Imported by instruction_loader; the bank address type is the one instruction_bank uses.
// Optional build macro consumed downstream: LOADER_CKSUM_EN (adds the trailer checksum state).
package instruction_loader_pkg;

  localparam int INSTR_DEPTH  = 256;
  localparam int INSTR_ADDR_W = $clog2(INSTR_DEPTH);

  typedef logic [INSTR_ADDR_W-1:0] InstructionAddr;

  // Upper half of the program header word.
  localparam logic [15:0] LOADER_MAGIC = 16'hB00C;

  // Loader FSM codes, kept as plain constants so older code can compare raw 2-bit values.
  typedef logic [1:0] loader_state_t;
  localparam loader_state_t IDLE  = 2'd0;
  localparam loader_state_t LOAD  = 2'd1;
  localparam loader_state_t CKSUM = 2'd2;
  localparam loader_state_t DRAIN = 2'd3;

endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: takes 32-bit words from the Ethernet aggregate stage, checks a
// {magic, count} header, writes count payload words into the instruction bank and reports
// done/error. Holds prog_valid/prog_len for the fetch stage.
// Build option: define LOADER_CKSUM_EN to require an XOR trailer word after the payload.
// Ports:
//   clk_50mhz, rst (sync, active high)
//   axiiv/axiid  word strobe + data in;  frame_end  one-cycle end-of-frame pulse
//   wr_en/wr_addr/wr_data  bank write port (registered, one cycle after the word)
//   busy, prog_valid, prog_len  status levels;  load_done/load_error  one-cycle pulses
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int          DEPTH          = INSTR_DEPTH,
  parameter logic [15:0] MAGIC          = LOADER_MAGIC,
  parameter int          TIMEOUT_CYCLES = 50_000,
  localparam int         ADDR_W         = $clog2(DEPTH)
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [31:0]       axiid,
  input  logic              frame_end,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              prog_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_done,
  output logic              load_error
);

  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [15:0]      DEPTH_W16 = 16'(DEPTH);
  localparam logic [ADDR_W:0]  IDX_ONE   = (ADDR_W+1)'(1);

  loader_state_t    state;
  logic [ADDR_W:0]  count;
  logic [ADDR_W:0]  idx;
  logic [TMR_W-1:0] idle_cnt;
`ifdef LOADER_CKSUM_EN
  logic [31:0]      csum;
`endif

  logic last_word;
  logic timeout_hit;

  // The word being accepted this cycle (if any) is the final payload word.
  assign last_word   = (idx + IDX_ONE) == count;
  // Fires on the cycle whose edge would bring the idle count up to the limit.
  assign timeout_hit = !axiiv && (idle_cnt == TMR_LAST);
  assign busy        = (state == LOAD) || (state == CKSUM);

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
      idle_cnt   <= '0;
`ifdef LOADER_CKSUM_EN
      csum       <= '0;
`endif
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      prog_valid <= 1'b0;
      prog_len   <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;

      // Idle gap counter: cleared by every word, saturates at the limit.
      if (axiiv) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TMR_MAX) begin
        idle_cnt <= idle_cnt + TMR_W'(1);
      end

      case (state)
        IDLE: begin
          // frame_end alone is meaningless here; only a header word moves us.
          if (axiiv) begin
            if (axiid[31:16] != MAGIC) begin
              load_error <= 1'b1;
              state      <= DRAIN;
            end else if (axiid[15:0] > DEPTH_W16) begin
              load_error <= 1'b1;
              state      <= DRAIN;
            end else if (axiid[15:0] == 16'd0) begin
              prog_len   <= '0;
              prog_valid <= 1'b1;
              load_done  <= 1'b1;
              state      <= DRAIN;
            end else begin
              prog_valid <= 1'b0;
              count      <= axiid[ADDR_W:0];
              idx        <= '0;
`ifdef LOADER_CKSUM_EN
              csum       <= '0;
`endif
              state      <= LOAD;
            end
          end
        end

        LOAD: begin
          if (axiiv) begin
            // The word is always written, even if the frame ends on this same cycle.
            wr_en   <= 1'b1;
            wr_addr <= idx[ADDR_W-1:0];
            wr_data <= axiid;
            idx     <= idx + IDX_ONE;
`ifdef LOADER_CKSUM_EN
            csum    <= csum ^ axiid;
            if (last_word && !frame_end) begin
              state <= CKSUM;
            end else if (frame_end) begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
`else
            if (last_word) begin
              prog_len   <= count;
              prog_valid <= 1'b1;
              load_done  <= 1'b1;
              // If the frame already ended there is nothing left to drain.
              state      <= frame_end ? IDLE : DRAIN;
            end else if (frame_end) begin
              load_error <= 1'b1;
              state      <= IDLE;
            end
`endif
          end else if (frame_end || timeout_hit) begin
            load_error <= 1'b1;
            state      <= IDLE;
          end
        end

`ifdef LOADER_CKSUM_EN
        CKSUM: begin
          if (axiiv) begin
            if (axiid == csum) begin
              prog_len   <= count;
              prog_valid <= 1'b1;
              load_done  <= 1'b1;
            end else begin
              prog_valid <= 1'b0;
              load_error <= 1'b1;
            end
            state <= frame_end ? IDLE : DRAIN;
          end else if (frame_end || timeout_hit) begin
            load_error <= 1'b1;
            state      <= IDLE;
          end
        end
`endif

        DRAIN: begin
          if (frame_end) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
